// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
// Holds source encodings and the ROB tag sizing used for defaults.
package cdb_arbiter_pkg;

    localparam int ROB_SZ_LOG = 4;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    localparam int CDB_DATA_W = 32;

    typedef enum logic {
        SRC_ALU = CDB_SRC_ALU,
        SRC_LSB = CDB_SRC_LSB
    } cdb_src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result buffer: small FIFO of {tag, data} beats.
// Ports: clk/rst, i_push + i_tag/i_data, i_pop, i_clear; o_head_*, o_count.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [TAG_W-1:0]        i_tag,
    input  logic [CDB_DATA_W-1:0]   i_data,
    input  logic                    i_pop,
    input  logic                    i_clear,
    output logic [TAG_W-1:0]        o_head_tag,
    output logic [CDB_DATA_W-1:0]   o_head_data,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0]      r_tag  [DEPTH];
    logic [CDB_DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    // Caller guarantees no push when full and no pop when empty.
    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tag[r_wptr]  <= i_tag;
                r_data[r_wptr] <= i_data;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_tag  = r_tag[r_rptr];
    assign o_head_data = r_data[r_rptr];
    assign o_count     = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and load results, broadcasts one per cycle.
// Ports: clk/rst/rdy/flush, alu_*/lsb_* valid-ready sources, cdb_* registered broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int TAG_W      = ROB_SZ_LOG + 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  alu_valid,
    input  logic [TAG_W-1:0]      alu_tag,
    input  logic [CDB_DATA_W-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsb_valid,
    input  logic [TAG_W-1:0]      lsb_tag,
    input  logic [CDB_DATA_W-1:0] lsb_data,
    output logic                  lsb_ready,
    output logic                  cdb_valid,
    output logic                  cdb_src,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [CDB_DATA_W-1:0] cdb_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]      w_alu_cnt;
    logic [CNT_W-1:0]      w_lsb_cnt;
    logic [TAG_W-1:0]      w_alu_htag;
    logic [TAG_W-1:0]      w_lsb_htag;
    logic [CDB_DATA_W-1:0] w_alu_hdata;
    logic [CDB_DATA_W-1:0] w_lsb_hdata;
    logic                  w_alu_ne;
    logic                  w_lsb_ne;
    logic                  w_active;
    logic                  w_clear;
    logic                  w_alu_push;
    logic                  w_lsb_push;
    logic                  w_pop_alu;
    logic                  w_pop_lsb;
    cdb_src_e              w_prio_nxt;

    cdb_src_e              r_prio;
    logic                  r_cdb_valid;
    logic                  r_cdb_src;
    logic [TAG_W-1:0]      r_cdb_tag;
    logic [CDB_DATA_W-1:0] r_cdb_data;

    assign w_alu_ne = (w_alu_cnt != '0);
    assign w_lsb_ne = (w_lsb_cnt != '0);
    assign w_active = rdy && !flush;
    assign w_clear  = rdy && flush;

    // Readiness depends only on occupancy, never on the valids.
    assign alu_ready = rdy && (w_alu_cnt < CNT_W'(FIFO_DEPTH));
    assign lsb_ready = rdy && (w_lsb_cnt < CNT_W'(FIFO_DEPTH));

    assign w_alu_push = alu_valid && alu_ready && !flush;
    assign w_lsb_push = lsb_valid && lsb_ready && !flush;

    // Round-robin only rotates when both sources contend.
    always_comb begin
        w_pop_alu  = 1'b0;
        w_pop_lsb  = 1'b0;
        w_prio_nxt = r_prio;
        if (w_active) begin
            case ({w_alu_ne, w_lsb_ne})
                2'b11: begin
                    if (r_prio == SRC_ALU) begin
                        w_pop_alu  = 1'b1;
                        w_prio_nxt = SRC_LSB;
                    end else begin
                        w_pop_lsb  = 1'b1;
                        w_prio_nxt = SRC_ALU;
                    end
                end
                2'b10:   w_pop_alu = 1'b1;
                2'b01:   w_pop_lsb = 1'b1;
                default: ;
            endcase
        end
    end

    cdb_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_alu_push),
        .i_tag       (alu_tag),
        .i_data      (alu_data),
        .i_pop       (w_pop_alu),
        .i_clear     (w_clear),
        .o_head_tag  (w_alu_htag),
        .o_head_data (w_alu_hdata),
        .o_count     (w_alu_cnt)
    );

    cdb_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lsb_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_lsb_push),
        .i_tag       (lsb_tag),
        .i_data      (lsb_data),
        .i_pop       (w_pop_lsb),
        .i_clear     (w_clear),
        .o_head_tag  (w_lsb_htag),
        .o_head_data (w_lsb_hdata),
        .o_count     (w_lsb_cnt)
    );

    // Tag/data hold their last value when idle; only valid matters then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= SRC_ALU;
            r_cdb_valid <= 1'b0;
            r_cdb_src   <= CDB_SRC_ALU;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_prio      <= SRC_ALU;
                r_cdb_valid <= 1'b0;
            end else begin
                r_prio      <= w_prio_nxt;
                r_cdb_valid <= w_pop_alu || w_pop_lsb;
                if (w_pop_alu) begin
                    r_cdb_src  <= CDB_SRC_ALU;
                    r_cdb_tag  <= w_alu_htag;
                    r_cdb_data <= w_alu_hdata;
                end else if (w_pop_lsb) begin
                    r_cdb_src  <= CDB_SRC_LSB;
                    r_cdb_tag  <= w_lsb_htag;
                    r_cdb_data <= w_lsb_hdata;
                end
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_src   = r_cdb_src;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;

    // Tag 0 means "no producer" and must never be offered as a result.
    a_alu_tag_nz: assert property (
        @(posedge clk) disable iff (rst) !(alu_valid && alu_tag == '0)
    ) else $error("alu beat offered with tag 0");

    a_lsb_tag_nz: assert property (
        @(posedge clk) disable iff (rst) !(lsb_valid && lsb_tag == '0)
    ) else $error("lsb beat offered with tag 0");

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 5 (`ROB_SZ_LOG+1): ROB tag width; tag 0 means "no producer".
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: per-source result buffer depth, power of two, >=2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global ready; low freezes all state.
REQ-006 SHALL have port flush  input  1  branch-mispredict clear.
REQ-007 SHALL have port alu_valid  input  1  ALU result offered.
REQ-008 SHALL have port alu_tag  input  TAG_W  ROB tag of ALU result.
REQ-009 SHALL have port alu_data  input  32  ALU result value.
REQ-010 SHALL have port alu_ready  output  1  ALU buffer can accept.
REQ-011 SHALL have port lsb_valid  input  1  load result offered.
REQ-012 SHALL have port lsb_tag  input  TAG_W  ROB tag of load result.
REQ-013 SHALL have port lsb_data  input  32  load result value.
REQ-014 SHALL have port lsb_ready  output  1  load buffer can accept.
REQ-015 SHALL have port cdb_valid  output  1  broadcast valid to RS, LSB and ROB.
REQ-016 SHALL have port cdb_src  output  1  0 = ALU, 1 = LSB.
REQ-017 SHALL have port cdb_tag  output  TAG_W  broadcast tag.
REQ-018 SHALL have port cdb_data  output  32  broadcast value.

Function
REQ-019 SHALL accept a source beat when valid & ready & rdy & !flush, in the same edge.
REQ-020 SHALL drive x_ready = rdy & (count_x < FIFO_DEPTH), with no combinational dependency on any valid input.
REQ-021 SHALL, each active cycle, select at most one non-empty FIFO head, pop it, and register it onto cdb_* at the next edge.
REQ-022 SHALL give minimum latency of 1 cycle: beat accepted at edge N into an empty FIFO appears on cdb at edge N+1.
REQ-023 SHALL arbitrate round-robin: when both FIFOs are non-empty, grant the source indicated by pointer prio, then set prio to the other source.
REQ-024 SHALL, when only one FIFO is non-empty, grant it and leave prio unchanged.
REQ-025 SHALL deassert cdb_valid for one cycle when both FIFOs are empty; cdb_tag/cdb_data are don't-care then.
REQ-026 SHALL keep each source's results in order (FIFO order, pointers wrap modulo FIFO_DEPTH).
REQ-027 SHALL allow push and pop of the same FIFO in one cycle when not full; when full, ready is already low, so no push occurs.
REQ-028 SHALL, on flush (with rdy high), empty both FIFOs, clear cdb_valid at the next edge, set prio to ALU, and drop any beat offered that cycle.
REQ-029 SHALL, with rdy low, hold FIFOs, prio and all cdb_* outputs unchanged.
REQ-030 SHALL flag as illegal (simulation assertion) a beat with valid high and tag 0.

Reset
REQ-031 SHALL, on rst, clear both FIFOs (count 0, pointers 0) and set prio = ALU, cdb_valid = 0, cdb_src = 0, cdb_tag = 0, cdb_data = 0.
REQ-032 SHALL give rst precedence over rdy and flush.

Structure
REQ-033 SHALL take `ROB_SZ_LOG and new macros `CDB_SRC_ALU = 0 and `CDB_SRC_LSB = 1 from def.v.
REQ-034 SHALL use one sub-module cdb_fifo (parameters TAG_W, DEPTH; push/pop/clear, head, count), instantiated twice.

Verification
REQ-035 SHALL pass: ALU beat tag 3 / data 0x11 at edge 1, LSB idle -> cdb_valid=1, src=0, tag 3, data 0x11 at edge 2, then 0 at edge 3.
REQ-036 SHALL pass: ALU tag 1 and LSB tag 2 offered together after reset -> cdb shows tag 1 (ALU), then tag 2 (LSB).
REQ-037 SHALL pass: ALU offers tags 4,5,6 back-to-back while LSB holds one beat -> alu_ready drops when the ALU FIFO is full; all four tags appear exactly once; ALU order is 4,5,6.
REQ-038 SHALL pass: two beats buffered, flush pulsed -> cdb_valid=0 the next cycle; neither beat ever broadcast; both readys high.
REQ-039 SHALL pass: rdy low for 3 cycles with cdb_valid=1 tag 7 -> outputs frozen, readys low, no beats accepted; tag 7 is broadcast only once after rdy returns.
REQ-040 SHALL pass: rst asserted mid-stream with both FIFOs full -> all outputs equal REQ-031 values at the next edge.
